uart_loader: RTL and testbench

Parametrised UART program loader: receives a length-prefixed image over a single RX line and emits full-width words with incrementing byte addresses for instruction/data memory initialisation. It is the next-generation replacement for the fixed 32-bit UART wrapper. It adds configurable clock/baud/width, mid-bit start validation, framing and length checking, explicit load completion, and an optional trailing checksum. It sits between the board RX pin and the memory write port of the RISC-V core.

---
 rtl/uart_loader_pkg.sv | 42 ++++
 rtl/uart_loader_rx_core.sv | 153 +++++++++++++++
 rtl/uart_loader.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared types and constants for the UART program loader.
// Optional feature macro: UART_LOADER_CHECKSUM_EN (adds the LD_CSUM state).
package uart_loader_pkg;

   // Number of little-endian bytes in the word-count header (and in the checksum trailer)
   localparam int HDR_BYTES  = 4;
   // Width of the trailing checksum and of its accumulator
   localparam int CSUM_WIDTH = 32;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [2:0] {
      LD_LEN   = 3'd0,
      LD_DATA  = 3'd1,
`ifdef UART_LOADER_CHECKSUM_EN
      LD_CSUM  = 3'd2,
`endif
      LD_DONE  = 3'd3,
      LD_ERROR = 3'd4
   } ld_state_t;

   // True while the loader is still consuming bytes of the image
   function automatic logic ld_is_active(input ld_state_t s);
      logic v;
      v = 1'b0;
      case (s)
         LD_LEN,
         LD_DATA:  v = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
         LD_CSUM:  v = 1'b1;
`endif
         default:  v = 1'b0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/uart_loader_rx_core.sv
// uart_rx_core: 8N1 receiver with input synchroniser, baud counter and
// mid-bit sampling. A start bit is only accepted if the line is still low
// half a bit after the falling edge.
module uart_rx_core
   import uart_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT   = 868,
   parameter int unsigned RX_SYNC_STAGES = 2
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       io_rx,
   output logic       byte_strb,
   output logic [7:0] byte_data,
   output logic       frame_err_strb
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [RX_SYNC_STAGES-1:0] r_sync;
   logic                      r_rx_prev;
   logic                      w_rx;
   logic                      w_fall;
   rx_state_t                 r_state;
   rx_state_t                 w_state_nxt;
   logic [CNT_W-1:0]          r_cnt;
   logic [2:0]                r_bit_idx;
   logic [7:0]                r_shift;
   logic                      w_half_tick;
   logic                      w_bit_tick;
   logic                      w_byte_strb_nxt;
   logic                      w_frame_err_nxt;

   assign w_rx        = r_sync[RX_SYNC_STAGES-1];
   assign w_fall      = r_rx_prev & ~w_rx;
   assign w_half_tick = (r_cnt == HALF_LAST);
   assign w_bit_tick  = (r_cnt == BIT_LAST);
   assign byte_data   = r_shift;

   // Synchronise the pin and keep the previous value for falling-edge detection
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync    <= {RX_SYNC_STAGES{1'b1}};
         r_rx_prev <= 1'b1;
      end else begin
         r_sync[0] <= io_rx;
         for (int i = 1; i < int'(RX_SYNC_STAGES); i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_rx_prev <= w_rx;
      end
   end

   // Receiver state register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= RX_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Receiver next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RX_IDLE: begin
            if (w_fall) w_state_nxt = RX_START;
            else        w_state_nxt = RX_IDLE;
         end
         RX_START: begin
            if (w_half_tick) begin
               if (w_rx) w_state_nxt = RX_IDLE;
               else      w_state_nxt = RX_DATA;
            end else begin
               w_state_nxt = RX_START;
            end
         end
         RX_DATA: begin
            if (w_bit_tick && (r_bit_idx == 3'd7)) w_state_nxt = RX_STOP;
            else                                   w_state_nxt = RX_DATA;
         end
         RX_STOP: begin
            if (w_bit_tick) w_state_nxt = RX_IDLE;
            else            w_state_nxt = RX_STOP;
         end
         default: w_state_nxt = RX_IDLE;
      endcase
   end

   // Baud counter, bit index and LSB-first shift register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt     <= {CNT_W{1'b0}};
         r_bit_idx <= 3'd0;
         r_shift   <= 8'd0;
      end else begin
         case (r_state)
            RX_IDLE: begin
               r_cnt     <= {CNT_W{1'b0}};
               r_bit_idx <= 3'd0;
            end
            RX_START: begin
               r_bit_idx <= 3'd0;
               if (w_half_tick) r_cnt <= {CNT_W{1'b0}};
               else             r_cnt <= r_cnt + CNT_W'(1);
            end
            RX_DATA: begin
               if (w_bit_tick) begin
                  r_cnt     <= {CNT_W{1'b0}};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  r_shift   <= {w_rx, r_shift[7:1]};
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (w_bit_tick) r_cnt <= {CNT_W{1'b0}};
               else            r_cnt <= r_cnt + CNT_W'(1);
            end
            default: r_cnt <= {CNT_W{1'b0}};
         endcase
      end
   end

   // Decode the stop-bit sample into a good-byte or framing-error event
   always_comb begin
      w_byte_strb_nxt = 1'b0;
      w_frame_err_nxt = 1'b0;
      if ((r_state == RX_STOP) && w_bit_tick) begin
         w_byte_strb_nxt = w_rx;
         w_frame_err_nxt = ~w_rx;
      end else begin
         w_byte_strb_nxt = 1'b0;
         w_frame_err_nxt = 1'b0;
      end
   end

   // Register the one-cycle strobes
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         byte_strb      <= 1'b0;
         frame_err_strb <= 1'b0;
      end else begin
         byte_strb      <= w_byte_strb_nxt;
         frame_err_strb <= w_frame_err_nxt;
      end
   end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: receives a length-prefixed image over UART and emits
// little-endian words with incrementing byte addresses.
// Optional feature macro: UART_LOADER_CHECKSUM_EN (32-bit trailing sum check).
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned            CLK_FREQ_HZ    = 100_000_000,
   parameter int unsigned            BAUD           = 115200,
   parameter int unsigned            DATA_WIDTH     = 32,
   parameter int unsigned            ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = {ADDR_WIDTH{1'b0}},
   parameter int unsigned            MAX_WORDS      = 1024,
   parameter int unsigned            RX_SYNC_STAGES = 2
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   io_rx,
   output logic                   data_valid,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic [ADDR_WIDTH-1:0]  byte_address,
   output logic                   busy,
   output logic                   load_done,
   output logic                   frame_error,
   output logic                   length_error,
   output logic                   checksum_error
);

   localparam int unsigned CLKS_PER_BIT   = CLK_FREQ_HZ / BAUD;
   localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
   localparam int unsigned BIDX_W         = $clog2(BYTES_PER_WORD) + 1;
   localparam int unsigned WCNT_W         = $clog2(MAX_WORDS + 1);
   localparam int unsigned BYTE_BITS      = 8;
   localparam logic [BIDX_W-1:0]     LAST_BYTE_IDX = BIDX_W'(BYTES_PER_WORD - 1);
   localparam logic [1:0]            LAST_HDR_IDX  = 2'(HDR_BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP     = ADDR_WIDTH'(BYTES_PER_WORD);
   localparam logic [31:0]           MAX_WORDS_32  = 32'(MAX_WORDS);
`ifdef UART_LOADER_CHECKSUM_EN
   localparam ld_state_t LD_AFTER_DATA = LD_CSUM;
`else
   localparam ld_state_t LD_AFTER_DATA = LD_DONE;
`endif

   logic                  w_byte_strb;
   logic [7:0]            w_byte_data;
   logic                  w_frame_err_strb;

   ld_state_t             r_state;
   ld_state_t             w_state_nxt;
   logic [1:0]            r_hdr_idx;
   logic [23:0]           r_len_lo;
   logic [31:0]           w_len_full;
   logic [BIDX_W-1:0]     r_byte_idx;
   logic [DATA_WIDTH-1:0] r_word;
   logic [DATA_WIDTH-1:0] w_word_full;
   logic [WCNT_W-1:0]     r_words_left;
   logic [ADDR_WIDTH-1:0] r_next_addr;
   logic                  w_hdr_last;
   logic                  w_word_last;
   logic                  w_last_word;
   logic                  w_emit;
   logic                  w_set_done;
   logic                  w_set_len_err;
   logic                  w_set_frame_err;
   logic                  w_busy_nxt;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [CSUM_WIDTH-1:0] r_csum;
   logic                  w_set_csum_err;
   logic                  r_csum_err;
`endif

   uart_rx_core #(
      .CLKS_PER_BIT   (CLKS_PER_BIT),
      .RX_SYNC_STAGES (RX_SYNC_STAGES)
   ) u_rx (
      .clk            (clk),
      .reset_n        (reset_n),
      .io_rx          (io_rx),
      .byte_strb      (w_byte_strb),
      .byte_data      (w_byte_data),
      .frame_err_strb (w_frame_err_strb)
   );

   // The header/checksum value with the current byte placed at the top
   assign w_len_full  = {w_byte_data, r_len_lo};
   // The word with the current byte shifted in at the top; after a full word
   // the first byte has reached bits [7:0]
   assign w_word_full = (r_word >> BYTE_BITS)
                      | (DATA_WIDTH'(w_byte_data) << (DATA_WIDTH - BYTE_BITS));
   assign w_hdr_last  = (r_hdr_idx == LAST_HDR_IDX);
   assign w_word_last = (r_byte_idx == LAST_BYTE_IDX);
   assign w_last_word = (r_words_left == WCNT_W'(1));

   // Loader state register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= LD_LEN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Loader next-state logic; a framing error anywhere but DONE is fatal
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         LD_LEN: begin
            if (w_frame_err_strb) begin
               w_state_nxt = LD_ERROR;
            end else if (w_byte_strb && w_hdr_last) begin
               if (w_len_full == 32'd0)              w_state_nxt = LD_DONE;
               else if (w_len_full > MAX_WORDS_32)   w_state_nxt = LD_ERROR;
               else                                  w_state_nxt = LD_DATA;
            end else begin
               w_state_nxt = LD_LEN;
            end
         end
         LD_DATA: begin
            if (w_frame_err_strb)                               w_state_nxt = LD_ERROR;
            else if (w_byte_strb && w_word_last && w_last_word) w_state_nxt = LD_AFTER_DATA;
            else                                                w_state_nxt = LD_DATA;
         end
`ifdef UART_LOADER_CHECKSUM_EN
         LD_CSUM: begin
            if (w_frame_err_strb)               w_state_nxt = LD_ERROR;
            else if (w_byte_strb && w_hdr_last) w_state_nxt = LD_DONE;
            else                                w_state_nxt = LD_CSUM;
         end
`endif
         LD_DONE:  w_state_nxt = LD_DONE;
         LD_ERROR: w_state_nxt = LD_ERROR;
         default:  w_state_nxt = LD_ERROR;
      endcase
   end

   // Loader output decode: word emission, flag set events and busy
   always_comb begin
      w_emit          = 1'b0;
      w_set_len_err   = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      w_set_csum_err  = 1'b0;
`endif
      w_set_frame_err = w_frame_err_strb && (r_state != LD_DONE);
      w_set_done      = (w_state_nxt == LD_DONE) && (r_state != LD_DONE);
      case (r_state)
         LD_LEN:  w_set_len_err  = w_byte_strb && w_hdr_last && (w_len_full > MAX_WORDS_32);
         LD_DATA: w_emit         = w_byte_strb && w_word_last;
`ifdef UART_LOADER_CHECKSUM_EN
         LD_CSUM: w_set_csum_err = w_byte_strb && w_hdr_last && (w_len_full != r_csum);
`endif
         default: w_emit         = 1'b0;
      endcase
      if (w_set_done || w_set_frame_err || w_set_len_err) begin
         w_busy_nxt = 1'b0;
      end else if (w_byte_strb && ld_is_active(r_state)) begin
         w_busy_nxt = 1'b1;
      end else begin
         w_busy_nxt = busy;
      end
   end

   // Header/checksum collection, word packing, word and address counters
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_hdr_idx    <= 2'd0;
         r_len_lo     <= 24'd0;
         r_byte_idx   <= {BIDX_W{1'b0}};
         r_word       <= {DATA_WIDTH{1'b0}};
         r_words_left <= {WCNT_W{1'b0}};
         r_next_addr  <= BASE_ADDR;
`ifdef UART_LOADER_CHECKSUM_EN
         r_csum       <= {CSUM_WIDTH{1'b0}};
`endif
      end else begin
         case (r_state)
            LD_LEN: begin
               if (w_byte_strb) begin
                  r_len_lo     <= w_len_full[31:8];
                  r_hdr_idx    <= r_hdr_idx + 2'd1;
                  r_words_left <= w_len_full[WCNT_W-1:0];
               end else begin
                  r_hdr_idx <= r_hdr_idx;
               end
            end
            LD_DATA: begin
               if (w_byte_strb) begin
                  r_word <= w_word_full;
                  if (w_word_last) begin
                     r_byte_idx   <= {BIDX_W{1'b0}};
                     r_words_left <= r_words_left - WCNT_W'(1);
                     r_next_addr  <= r_next_addr + ADDR_STEP;
`ifdef UART_LOADER_CHECKSUM_EN
                     r_csum       <= r_csum + CSUM_WIDTH'(w_word_full);
`endif
                  end else begin
                     r_byte_idx <= r_byte_idx + BIDX_W'(1);
                  end
               end else begin
                  r_byte_idx <= r_byte_idx;
               end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            LD_CSUM: begin
               if (w_byte_strb) begin
                  r_len_lo  <= w_len_full[31:8];
                  r_hdr_idx <= r_hdr_idx + 2'd1;
               end else begin
                  r_hdr_idx <= r_hdr_idx;
               end
            end
`endif
            default: r_hdr_idx <= r_hdr_idx;
         endcase
      end
   end

   // Registered outputs: word/address presentation and sticky status flags
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_valid   <= 1'b0;
         data_out     <= {DATA_WIDTH{1'b0}};
         byte_address <= BASE_ADDR;
         busy         <= 1'b0;
         load_done    <= 1'b0;
         frame_error  <= 1'b0;
         length_error <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
         r_csum_err   <= 1'b0;
`endif
      end else begin
         data_valid <= w_emit;
         if (w_emit) begin
            data_out     <= w_word_full;
            byte_address <= r_next_addr;
         end else begin
            data_out     <= data_out;
            byte_address <= byte_address;
         end
         busy         <= w_busy_nxt;
         load_done    <= load_done    | w_set_done;
         frame_error  <= frame_error  | w_set_frame_err;
         length_error <= length_error | w_set_len_err;
`ifdef UART_LOADER_CHECKSUM_EN
         r_csum_err   <= r_csum_err   | w_set_csum_err;
`endif
      end
   end

`ifdef UART_LOADER_CHECKSUM_EN
   assign checksum_error = r_csum_err;
`else
   assign checksum_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: scoreboard bench for uart_loader. A shortened bit period
// keeps the run short; the design is otherwise at its default configuration.
module tb_uart_loader;

   localparam int CLK_HZ = 1_600_000;
   localparam int BAUD_R = 100_000;
   localparam int CPB    = CLK_HZ / BAUD_R;   // 16 clocks per bit
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        io_rx = 1'b1;
   logic        data_valid;
   logic [31:0] data_out;
   logic [31:0] byte_address;
   logic        busy, load_done, frame_error, length_error, checksum_error;

   typedef struct {
      logic [31:0] data;
      logic [31:0] addr;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   uart_loader #(
      .CLK_FREQ_HZ    (CLK_HZ),
      .BAUD           (BAUD_R),
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (32),
      .BASE_ADDR      (BASE),
      .MAX_WORDS      (1024),
      .RX_SYNC_STAGES (2)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .io_rx          (io_rx),
      .data_valid     (data_valid),
      .data_out       (data_out),
      .byte_address   (byte_address),
      .busy           (busy),
      .load_done      (load_done),
      .frame_error    (frame_error),
      .length_error   (length_error),
      .checksum_error (checksum_error)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every data_valid pulse is matched against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && data_valid) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: got %h @ %h, expected no word", data_out, byte_address);
         end else begin
            e = sb_q.pop_front();
            check("word_data", {32'd0, data_out}, {32'd0, e.data});
            check("word_addr", {32'd0, byte_address}, {32'd0, e.addr});
         end
      end
   end

   initial begin
      #950_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic exp_cerr(input bit bad);
`ifdef UART_LOADER_CHECKSUM_EN
      return bad;
`else
      return 1'b0 & bad;
`endif
   endfunction

   task automatic idle(input int n);
      io_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // One 8N1 frame; starts and ends on a falling clock edge
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      io_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         io_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      io_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      io_rx = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      io_rx   = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      sb_q.delete();
      repeat (CPB) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, {63'd0, data_valid}, 64'd0);
      check({tag, "_data"},  {32'd0, data_out}, 64'd0);
      check({tag, "_addr"},  {32'd0, byte_address}, {32'd0, BASE});
      check({tag, "_flags"}, {59'd0, busy, load_done, frame_error, length_error, checksum_error}, 64'd0);
   endtask

   task automatic check_flags(input string tag, input logic b, input logic d,
                              input logic fe, input logic le, input logic ce);
      repeat (4) @(negedge clk);
      check({tag, "_busy"}, {63'd0, busy}, {63'd0, b});
      check({tag, "_done"}, {63'd0, load_done}, {63'd0, d});
      check({tag, "_ferr"}, {63'd0, frame_error}, {63'd0, fe});
      check({tag, "_lerr"}, {63'd0, length_error}, {63'd0, le});
      check({tag, "_cerr"}, {63'd0, checksum_error}, {63'd0, ce});
      check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
   endtask

   // Build header + little-endian words (+ checksum) and send them.
   // Expected words are queued when expect_out is set.
   task automatic send_words(input logic [31:0] hdr, input logic [31:0] words[$],
                             input bit csum_bad, input bit expect_out,
                             input bit busy_exp, input int gap_max);
      logic [7:0]  bytes[$];
      logic [31:0] sum;
      logic [31:0] w;
      bytes = {};
      sum = 32'd0;
      for (int b = 0; b < 4; b++) bytes.push_back(hdr[8*b +: 8]);
      foreach (words[k]) begin
         w = words[k];
         sum = sum + w;
         if (expect_out) sb_q.push_back('{data: w, addr: BASE + 32'(4 * k)});
         for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
      end
`ifdef UART_LOADER_CHECKSUM_EN
      if ((words.size() > 0) && (hdr == 32'(words.size()))) begin
         if (csum_bad) sum = sum + 32'd1;
         for (int b = 0; b < 4; b++) bytes.push_back(sum[8*b +: 8]);
      end
`endif
      foreach (bytes[i]) begin
         send_byte(bytes[i], 1'b1);
         if (i == 0) check("busy_after_first_byte", {63'd0, busy}, {63'd0, busy_exp});
         if (gap_max > 0) idle($urandom_range(gap_max, 0));
      end
   endtask

   initial begin
      logic [31:0] wq[$];
      int          n;

      // Reset state
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_reset_values("reset");

      // Directed two-word image
      do_reset();
      wq = {32'h0403_0201, 32'hDEAD_BEEF};
      send_words(32'd2, wq, 1'b0, 1'b1, 1'b1, 0);
      check_flags("two_words", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Empty image
      do_reset();
      wq = {};
      send_words(32'd0, wq, 1'b0, 1'b0, 1'b1, 0);
      check_flags("empty", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Framing error on the third data byte
      do_reset();
      send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b0);
      idle(CPB);
      send_byte(8'h04, 1'b1); send_byte(8'hEF, 1'b1);
      send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1);
      send_byte(8'hDE, 1'b1);
      check_flags("frame_err", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Oversized header, then a valid image that must be ignored
      do_reset();
      wq = {};
      send_words(32'd1025, wq, 1'b0, 1'b0, 1'b1, 0);
      check_flags("len_err", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      wq = {32'h1111_2222, 32'h3333_4444};
      send_words(32'd2, wq, 1'b0, 1'b0, 1'b0, 0);
      check_flags("len_err_ignore", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Short glitch (false start), then reset in the middle of a frame
      do_reset();
      io_rx = 1'b0;
      repeat (5) @(negedge clk);
      idle(2 * CPB);
      check("glitch_no_byte", {63'd0, busy}, 64'd0);
      send_byte(8'h01, 1'b1);
      check("busy_before_abort", {63'd0, busy}, 64'd1);
      io_rx = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      reset_n = 1'b0;
      io_rx   = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_reset_values("mid_frame_reset");
      idle(2 * CPB);
      wq = {32'hCAFE_F00D};
      send_words(32'd1, wq, 1'b0, 1'b1, 1'b1, 0);
      check_flags("after_abort", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef UART_LOADER_CHECKSUM_EN
      // Checksum good and bad
      do_reset();
      wq = {32'd1, 32'd2};
      send_words(32'd2, wq, 1'b0, 1'b1, 1'b1, 0);
      check_flags("csum_ok", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      do_reset();
      wq = {32'd1, 32'd2};
      send_words(32'd2, wq, 1'b1, 1'b1, 1'b1, 0);
      check_flags("csum_bad", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

      // Randomised images, alternating back-to-back and gapped frames
      for (int it = 0; it < 6; it++) begin
         bit bad;
         do_reset();
         n = $urandom_range(5, 1);
         wq = {};
         for (int k = 0; k < n; k++) wq.push_back($urandom);
         bad = 1'($urandom_range(1, 0));
         send_words(32'(n), wq, bad, 1'b1, 1'b1, (it % 2 == 0) ? 0 : 20);
         check_flags("random", 1'b0, 1'b1, 1'b0, 1'b0, exp_cerr(bad));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
